// File: rtl/rx_fifo.sv
// rx_fifo: receive-side byte FIFO with line-status reporting.
// Each entry is 10 bits wide: {frame error, parity error, data}.
// A write happens on the rising edge of rx_done. Reads are registered into
// dout with one cycle of latency.
// Optional build macro RX_TRIGGER_LEVEL_EN selects a programmable occupancy
// threshold for trig_irq. Without it, trig_irq is simply "not empty".
module rx_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_done,
  input  logic          rx_pe,
  input  logic          rx_fe,
  input  logic          rd_en,
  input  logic          lsr_rd,
  input  logic          fifo_clr,
  input  logic [1:0]    trig_lvl,
  output logic [7:0]    dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic [7:0]    lsr,
  output logic          trig_irq
);

  localparam int unsigned DEPTH   = 2 ** AW;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          rx_done_q;
  logic          ovr_q;
  logic          err_q;

  logic          wr_ev;
  logic          rd_ok;
  logic          wr_ok;
  logic          ovr_set;
  logic          err_set;
  logic [9:0]    head;

  // Flags come only from the registered occupancy count.
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // Accept decisions. A flush overrides both directions. When the FIFO is
  // full, a same-cycle read frees the slot, so the write is also accepted.
  always_comb begin
    wr_ev   = rx_done & ~rx_done_q;
    rd_ok   = rd_en & ~empty & ~fifo_clr;
    wr_ok   = wr_ev & ~fifo_clr & (~full | rd_ok);
    ovr_set = wr_ev & ~fifo_clr & full & ~rd_ok;
    err_set = wr_ok & (rx_pe | rx_fe);
  end

  // Entry storage. It has no reset, because emptiness is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= {rx_fe, rx_pe, rx_data};
    end
  end

  // Pointers, occupancy and rx_done edge detector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rx_done_q <= 1'b0;
    end else begin
      rx_done_q <= rx_done;
      if (fifo_clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_ok) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (rd_ok) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({wr_ok, rd_ok})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Registered read data. It holds on ignored reads and across a flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout <= '0;
    end else if (rd_ok) begin
      dout <= mem[rd_ptr][7:0];
    end
  end

  // Sticky status bits. A set event in the same cycle as lsr_rd wins over the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovr_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (ovr_set) begin
        ovr_q <= 1'b1;
      end else if (lsr_rd) begin
        ovr_q <= 1'b0;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end else if (lsr_rd) begin
        err_q <= 1'b0;
      end
    end
  end

  // Line status. The head-entry error bits are masked while the FIFO is empty.
  always_comb begin
    head = empty ? '0 : mem[rd_ptr];
    lsr  = {err_q, 3'b000, head[9], head[8], ovr_q, ~empty};
  end

`ifdef RX_TRIGGER_LEVEL_EN
  logic [AW:0] thr;

  function automatic logic [AW:0] sat_depth(input int unsigned lvl);
    if (lvl > DEPTH) begin
      return DEPTH_C;
    end
    return (AW + 1)'(lvl);
  endfunction

  // Occupancy threshold for the data-available interrupt.
  always_comb begin
    thr = sat_depth(1);
    case (trig_lvl)
      2'd0:    thr = sat_depth(1);
      2'd1:    thr = sat_depth(4);
      2'd2:    thr = sat_depth(8);
      default: thr = sat_depth(14);
    endcase
  end

  assign trig_irq = (count >= thr);
`else
  logic unused_trig_lvl;

  assign unused_trig_lvl = ^trig_lvl;
  assign trig_irq        = ~empty;
`endif

endmodule

// File: tb/tb_rx_fifo.sv
// tb_rx_fifo: self-checking bench for rx_fifo.
// A queue model holds the expected FIFO contents. Entries are pushed when a
// write is driven and popped when a read is expected to produce dout.
module tb_rx_fifo;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_done;
  logic          rx_pe;
  logic          rx_fe;
  logic          rd_en;
  logic          lsr_rd;
  logic          fifo_clr;
  logic [1:0]    trig_lvl;
  logic [7:0]    dout;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic [7:0]    lsr;
  logic          trig_irq;

  int checks   = 0;
  int failures = 0;

  logic [9:0] sb[$];
  logic       m_ovr;
  logic       m_err;
  logic       m_doneq;
  logic [7:0] m_dout;

  rx_fifo #(.AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .rx_pe    (rx_pe),
    .rx_fe    (rx_fe),
    .rd_en    (rd_en),
    .lsr_rd   (lsr_rd),
    .fifo_clr (fifo_clr),
    .trig_lvl (trig_lvl),
    .dout     (dout),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .lsr      (lsr),
    .trig_irq (trig_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_lsr();
    logic [9:0] h;
    h = (sb.size() != 0) ? sb[0] : 10'd0;
    return {m_err, 3'b000, h[9], h[8], m_ovr, (sb.size() != 0)};
  endfunction

  function automatic logic exp_trig();
`ifdef RX_TRIGGER_LEVEL_EN
    int thr;
    case (trig_lvl)
      2'd0:    thr = 1;
      2'd1:    thr = 4;
      2'd2:    thr = 8;
      default: thr = 14;
    endcase
    if (thr > DEPTH) thr = DEPTH;
    return sb.size() >= thr;
`else
    return sb.size() != 0;
`endif
  endfunction

  task automatic check_all();
    chk("count", 32'(count), 32'(sb.size()));
    chk("full", 32'(full), 32'(sb.size() == DEPTH));
    chk("empty", 32'(empty), 32'(sb.size() == 0));
    chk("lsr", 32'(lsr), 32'(exp_lsr()));
    chk("trig_irq", 32'(trig_irq), 32'(exp_trig()));
    chk("dout", 32'(dout), 32'(m_dout));
  endtask

  // One clock cycle: drive inputs, advance the model, and compare after the edge.
  task automatic cyc(input logic d, input logic [7:0] data, input logic pe, input logic fe,
                     input logic rd, input logic lr, input logic clr);
    logic wr, rdok, fl, ovr_set, err_set;
    rx_done = d; rx_data = data; rx_pe = pe; rx_fe = fe;
    rd_en = rd; lsr_rd = lr; fifo_clr = clr;
    wr      = d & ~m_doneq;
    fl      = (sb.size() == DEPTH);
    rdok    = rd && (sb.size() != 0);
    ovr_set = 1'b0;
    err_set = 1'b0;
    @(posedge clk); #1;
    if (clr) begin
      sb.delete();
    end else begin
      if (rdok) begin
        m_dout = sb[0][7:0];
        void'(sb.pop_front());
      end
      if (wr) begin
        if (!fl || rdok) begin
          sb.push_back({fe, pe, data});
          err_set = pe | fe;
        end else begin
          ovr_set = 1'b1;
        end
      end
    end
    if (lr) begin m_ovr = 1'b0; m_err = 1'b0; end
    if (ovr_set) m_ovr = 1'b1;
    if (err_set) m_err = 1'b1;
    m_doneq = d;
    check_all();
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic write_byte(input logic [7:0] b, input logic pe, input logic fe);
    cyc(1'b1, b, pe, fe, 1'b0, 1'b0, 1'b0);
    idle();
  endtask

  task automatic read_byte();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    sb.delete();
    m_ovr = 1'b0; m_err = 1'b0; m_doneq = 1'b0; m_dout = 8'h00;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, " count"}, 32'(count), 32'd0);
    chk({tag, " empty"}, 32'(empty), 32'd1);
    chk({tag, " full"}, 32'(full), 32'd0);
    chk({tag, " lsr"}, 32'(lsr), 32'd0);
    chk({tag, " dout"}, 32'(dout), 32'd0);
    chk({tag, " trig_irq"}, 32'(trig_irq), 32'd0);
  endtask

  typedef struct {
    logic       d;
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       rd;
    logic       lr;
    logic [7:0] exp_dout;
    logic [4:0] exp_count;
    logic [7:0] exp_lsr;
  } vec_t;

  vec_t vec[13];

  initial begin
    // d, data, pe, fe, rd, lr, dout, count, lsr
    vec[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 8'h01};
    vec[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 8'h01};
    vec[2]  = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd2, 8'h01};
    vec[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd2, 8'h01};
    vec[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h41, 5'd1, 8'h01};
    vec[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h42, 5'd0, 8'h00};
    vec[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h42, 5'd0, 8'h00};
    vec[7]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 8'h42, 5'd1, 8'h85};
    vec[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h42, 5'd1, 8'h85};
    vec[9]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 8'h42, 5'd2, 8'h85};
    vec[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 5'd1, 8'h81};
    vec[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 5'd1, 8'h01};
    vec[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h44, 5'd0, 8'h00};

    reset = 1'b0; rx_data = '0; rx_done = 1'b0; rx_pe = 1'b0; rx_fe = 1'b0;
    rd_en = 1'b0; lsr_rd = 1'b0; fifo_clr = 1'b0; trig_lvl = 2'b01;
    model_reset();
    #2;
    reset_checks("por");
    @(posedge clk); #1;
    reset = 1'b1;

    // Basic two-byte transfer followed by a parity-error entry.
    for (int i = 0; i < 13; i++) begin
      cyc(vec[i].d, vec[i].data, vec[i].pe, vec[i].fe, vec[i].rd, vec[i].lr, 1'b0);
      chk($sformatf("vec%0d dout", i), 32'(dout), 32'(vec[i].exp_dout));
      chk($sformatf("vec%0d count", i), 32'(count), 32'(vec[i].exp_count));
      chk($sformatf("vec%0d lsr", i), 32'(lsr), 32'(vec[i].exp_lsr));
    end

    // Overflow: 17 writes into 16 slots.
    for (int i = 0; i < 17; i++) write_byte(8'(i), 1'b0, 1'b0);
    chk("ovf full", 32'(full), 32'd1);
    chk("ovf lsr1", 32'(lsr[1]), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovf lsr1 cleared", 32'(lsr[1]), 32'd0);
    for (int i = 0; i < 16; i++) begin
      read_byte();
      chk($sformatf("ovf read%0d", i), 32'(dout), 32'(i));
    end
    chk("ovf drained", 32'(empty), 32'd1);

    // A held rx_done produces exactly one entry.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    chk("held count", 32'(count), 32'd1);
`ifdef RX_TRIGGER_LEVEL_EN
    chk("trig 1 entry", 32'(trig_irq), 32'd0);
    write_byte(8'h56, 1'b0, 1'b0);
    write_byte(8'h57, 1'b0, 1'b0);
    chk("trig 3 entries", 32'(trig_irq), 32'd0);
    write_byte(8'h58, 1'b0, 1'b0);
    chk("trig 4 entries", 32'(trig_irq), 32'd1);
    for (int i = 0; i < 3; i++) read_byte();
`else
    chk("trig 1 entry", 32'(trig_irq), 32'd1);
`endif
    read_byte();
    chk("held empty", 32'(empty), 32'd1);

    // Full FIFO with a simultaneous read and write.
    for (int i = 0; i < 16; i++) write_byte(8'h80 + 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rw full count", 32'(count), 32'd16);
    chk("rw full ovr", 32'(lsr[1]), 32'd0);
    chk("rw full dout", 32'(dout), 32'h80);
    idle();
    for (int i = 0; i < 16; i++) read_byte();
    chk("rw newest last", 32'(dout), 32'hAA);

    // A flush overrides a same-cycle read and write, and dout holds.
    write_byte(8'h10, 1'b0, 1'b0);
    write_byte(8'h11, 1'b0, 1'b0);
    write_byte(8'h12, 1'b0, 1'b0);
    read_byte();
    cyc(1'b1, 8'h99, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("clr count", 32'(count), 32'd0);
    chk("clr dout", 32'(dout), 32'h10);
    chk("clr lsr7", 32'(lsr[7]), 32'd0);
    idle();

    // A reset asserted mid-operation discards the entries.
    write_byte(8'h21, 1'b1, 1'b0);
    write_byte(8'h22, 1'b0, 1'b0);
    read_byte();
    reset = 1'b0;
    #2;
    model_reset();
    reset_checks("midrst");
    @(posedge clk); #1;
    reset = 1'b1;
    write_byte(8'h5A, 1'b0, 1'b1);
    chk("post rst lsr", 32'(lsr), 32'h89);
    read_byte();
    chk("post rst dout", 32'(dout), 32'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
